counter_modulo_ud: RTL and testbench

//  Parametrised successor to the 8-bit free-running counter. Adds up/down counting,
//  a programmable modulus, wrap or saturate mode, synchronous load/clear, enable,
//  a built-in prescaler and status flags.

---
 rtl/counter_pkg.sv | 20 ++
 rtl/counter_prescaler.sv | 40 ++++
 rtl/counter_modulo_ud.sv | 93 +++++++++
 tb/tb_counter_modulo_ud.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the counter family.
//   COUNTER_MODE_WRAP / COUNTER_MODE_SAT : values for the SATURATE parameter
//   PRESCALE_MAX                         : largest supported prescale ratio
//   clog2()                              : bit width needed to hold 0..v-1 (minimum 1)
package counter_pkg;

    localparam int COUNTER_MODE_WRAP = 0;
    localparam int COUNTER_MODE_SAT  = 1;
    localparam int PRESCALE_MAX      = 65535;

    // Width of a counter that runs 0..v-1; never less than one bit so that
    // a divide-by-1 prescaler still has a legal (constant-zero) register.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Cycle prescaler for the modulo counter.
//   clk     : rising-edge clock
//   reset   : asynchronous, active-low
//   en      : advances the prescaler; en==0 freezes it
//   restart : synchronous return to 0 (used on clear/load), suppresses tick
//   tick    : single-cycle step strobe, once every PRESCALE enabled cycles
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic restart,
    output logic tick
);

    localparam int                CW   = clog2(PRESCALE);
    localparam logic [CW-1:0]     LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    // With PRESCALE==1, LAST is 0 and cnt never leaves 0, so every enabled
    // cycle ticks.
    assign tick = en && !restart && (cnt == LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, regardless of the order the processes are evaluated in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/counter_modulo_ud.sv
// Up/down modulo counter with wrap or saturate mode, synchronous clear/load,
// enable, prescaler and status flags.
//   clk        : rising-edge clock
//   reset      : asynchronous, active-low
//   en         : count enable (drives the prescaler)
//   up         : 1 = increment, 0 = decrement, sampled at the stepping edge
//   clear      : synchronous clear to 0 (highest priority)
//   load       : synchronous load of load_value, clamped to MODULUS-1
//   load_value : value to load
//   value      : registered count, 0..MODULUS-1
//   tc         : terminal count for the current direction (combinational)
//   wrap       : one-cycle pulse after a wrap-around step
//   sat        : sticky, set when a step was blocked at a range end
module counter_modulo_ud
    import counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MODULUS  = 256,
    parameter int SATURATE = COUNTER_MODE_WRAP,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] value,
    output logic             tc,
    output logic             wrap,
    output logic             sat
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic             tick;
    logic             at_end;
    logic [WIDTH-1:0] next_value;
    logic [WIDTH-1:0] load_clamped;

    counter_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .restart(clear | load),
        .tick   (tick)
    );

    // NOTE: every signal driven here gets a value on every path (defaults
    // first) so no latch is inferred.
    always_comb begin
        at_end       = up ? (value == MAX_VAL) : (value == '0);
        next_value   = up ? value + WIDTH'(1) : value - WIDTH'(1);
        // Range ends are handled explicitly so a non-power-of-2 MODULUS wraps
        // exactly like a full-width one, without relying on overflow.
        if (at_end) begin
            next_value = up ? '0 : MAX_VAL;
        end
        load_clamped = (load_value > MAX_VAL) ? MAX_VAL : load_value;
    end

    assign tc = at_end;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= '0;
            wrap  <= 1'b0;
            sat   <= 1'b0;
        end else if (clear) begin
            value <= '0;
            wrap  <= 1'b0;
            sat   <= 1'b0;
        end else if (load) begin
            value <= load_clamped;
            wrap  <= 1'b0;
            sat   <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (tick) begin
                if (at_end && (SATURATE == COUNTER_MODE_SAT)) begin
                    sat <= 1'b1;
                end else begin
                    value <= next_value;
                    wrap  <= at_end;
                end
            end
        end
    end

endmodule

// File: tb/tb_counter_modulo_ud.sv
// Self-checking bench for counter_modulo_ud. Three instances share the same
// stimulus: d0 wrap/PRESCALE=1, d1 saturate/PRESCALE=1, d2 wrap/PRESCALE=4,
// all WIDTH=8, MODULUS=10. A behavioural model tracks all three.
module tb_counter_modulo_ud;

    localparam int M       = 10;
    localparam int NI      = 3;
    localparam int SATS[NI] = '{0, 1, 0};
    localparam int PRES[NI] = '{1, 1, 4};

    logic       clk = 1'b0;
    logic       reset;
    logic       en, up, clear, load;
    logic [7:0] load_value;
    logic [7:0] val_o [NI];
    logic [NI-1:0] tc_o, wrap_o, sat_o;

    int checks   = 0;
    int failures = 0;

    // behavioural model state
    int m_val [NI];
    int m_pre [NI];
    bit m_wrap[NI];
    bit m_sat [NI];

    always #5 clk = ~clk;

    counter_modulo_ud #(.WIDTH(8), .MODULUS(M), .SATURATE(0), .PRESCALE(1)) d0 (
        .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
        .load_value(load_value), .value(val_o[0]), .tc(tc_o[0]), .wrap(wrap_o[0]), .sat(sat_o[0]));
    counter_modulo_ud #(.WIDTH(8), .MODULUS(M), .SATURATE(1), .PRESCALE(1)) d1 (
        .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
        .load_value(load_value), .value(val_o[1]), .tc(tc_o[1]), .wrap(wrap_o[1]), .sat(sat_o[1]));
    counter_modulo_ud #(.WIDTH(8), .MODULUS(M), .SATURATE(0), .PRESCALE(4)) d2 (
        .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
        .load_value(load_value), .value(val_o[2]), .tc(tc_o[2]), .wrap(wrap_o[2]), .sat(sat_o[2]));

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_val[i] = 0; m_pre[i] = 0; m_wrap[i] = 0; m_sat[i] = 0;
        end
    endtask

    // One clock edge of the specified behaviour, using the inputs as sampled.
    task automatic model_edge();
        for (int i = 0; i < NI; i++) begin
            if (!reset) begin
                m_val[i] = 0; m_pre[i] = 0; m_wrap[i] = 0; m_sat[i] = 0;
            end else if (clear) begin
                m_val[i] = 0; m_pre[i] = 0; m_wrap[i] = 0; m_sat[i] = 0;
            end else if (load) begin
                m_val[i]  = (int'(load_value) > M - 1) ? M - 1 : int'(load_value);
                m_pre[i]  = 0; m_wrap[i] = 0; m_sat[i] = 0;
            end else begin
                m_wrap[i] = 0;
                if (en) begin
                    m_pre[i] = (m_pre[i] + 1) % PRES[i];
                    if (m_pre[i] == 0) begin
                        bit limit;
                        limit = up ? (m_val[i] == M - 1) : (m_val[i] == 0);
                        if (limit && SATS[i] != 0) begin
                            m_sat[i] = 1;
                        end else begin
                            m_wrap[i] = limit;
                            m_val[i]  = (m_val[i] + (up ? 1 : M - 1)) % M;
                        end
                    end
                end
            end
        end
    endtask

    task automatic check_model(input string tag);
        for (int i = 0; i < NI; i++) begin
            int exp_tc;
            exp_tc = up ? int'(m_val[i] == M - 1) : int'(m_val[i] == 0);
            check($sformatf("%s d%0d value", tag, i), int'(val_o[i]),  m_val[i]);
            check($sformatf("%s d%0d tc", tag, i),    int'(tc_o[i]),   exp_tc);
            check($sformatf("%s d%0d wrap", tag, i),  int'(wrap_o[i]), int'(m_wrap[i]));
            check($sformatf("%s d%0d sat", tag, i),   int'(sat_o[i]),  int'(m_sat[i]));
        end
    endtask

    // Inputs are driven while clk is low; one edge, then sample at negedge.
    task automatic drive(input logic e, input logic u, input logic c, input logic l, input int lv);
        en = e; up = u; clear = c; load = l; load_value = 8'(lv);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    typedef struct {
        bit en, up, clr, ld;
        int lv;
        int val;
        bit tc, wrap, sat;
    } vec_t;

    vec_t vecs[18];

    initial begin
        // ---- table of directed vectors, expected values for d0 ----
        for (int k = 1; k <= 9; k++) vecs[k-1] = '{1, 1, 0, 0, 0, k, (k == 9), 0, 0};
        vecs[9]  = '{1, 1, 0, 0, 0,   0, 0, 1, 0};  // 9 -> 0 wrap
        vecs[10] = '{1, 1, 0, 0, 0,   1, 0, 0, 0};  // wrap drops
        vecs[11] = '{1, 0, 1, 0, 0,   0, 1, 0, 0};  // clear, down: tc at 0
        vecs[12] = '{1, 0, 0, 0, 0,   9, 0, 1, 0};  // 0 -> 9 wrap
        vecs[13] = '{1, 0, 0, 0, 0,   8, 0, 0, 0};
        vecs[14] = '{0, 0, 0, 0, 0,   8, 0, 0, 0};  // hold
        vecs[15] = '{1, 1, 1, 1, 5,   0, 0, 0, 0};  // clear beats load
        vecs[16] = '{0, 1, 0, 1, 200, 9, 1, 0, 0};  // load clamps
        vecs[17] = '{1, 1, 0, 1, 3,   3, 0, 0, 0};  // load beats step

        reset = 1'b0; en = 0; up = 0; clear = 0; load = 0; load_value = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("reset value", int'(val_o[0]), 0);
        check("reset wrap", int'(wrap_o[0]), 0);
        check("reset sat", int'(sat_o[1]), 0);
        check("reset tc down", int'(tc_o[0]), 1);
        up = 1'b1;
        #1;
        check("reset tc up", int'(tc_o[0]), 0);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[k]) begin
            drive(vecs[k].en, vecs[k].up, vecs[k].clr, vecs[k].ld, vecs[k].lv);
            check($sformatf("vec%0d value", k), int'(val_o[0]),  vecs[k].val);
            check($sformatf("vec%0d tc", k),    int'(tc_o[0]),   int'(vecs[k].tc));
            check($sformatf("vec%0d wrap", k),  int'(wrap_o[0]), int'(vecs[k].wrap));
            check($sformatf("vec%0d sat", k),   int'(sat_o[0]),  int'(vecs[k].sat));
            check_model($sformatf("vec%0d", k));
        end

        // ---- saturate mode on d1 ----
        drive(0, 1, 0, 1, 7);
        check("sat load7", int'(val_o[1]), 7);
        drive(1, 1, 0, 0, 0);
        check("sat step8", int'(val_o[1]), 8);
        drive(1, 1, 0, 0, 0);
        check("sat step9", int'(val_o[1]), 9);
        check("sat not yet", int'(sat_o[1]), 0);
        check("sat tc9", int'(tc_o[1]), 1);
        drive(1, 1, 0, 0, 0);
        check("sat hold9", int'(val_o[1]), 9);
        check("sat set", int'(sat_o[1]), 1);
        check("sat no wrap", int'(wrap_o[1]), 0);
        drive(1, 1, 0, 0, 0);
        check("sat sticky", int'(sat_o[1]), 1);
        drive(0, 1, 0, 1, 3);
        check("sat load3 value", int'(val_o[1]), 3);
        check("sat load3 flag", int'(sat_o[1]), 0);
        check_model("satseq");

        // ---- prescaler on d2, with a 2-cycle enable gap ----
        drive(0, 1, 1, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            drive(1, 1, 0, 0, 0);
            check($sformatf("pre edge%0d", k), int'(val_o[2]), 0);
        end
        drive(1, 1, 0, 0, 0);
        check("pre edge4", int'(val_o[2]), 1);
        drive(1, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        check("pre delayed not yet", int'(val_o[2]), 1);
        drive(1, 1, 0, 0, 0);
        check("pre delayed step", int'(val_o[2]), 2);
        check_model("preseq");

        // ---- asynchronous reset mid-count ----
        drive(0, 1, 0, 1, 9);
        drive(1, 1, 0, 0, 0);   // d0 wraps to 0, d1 saturates
        for (int k = 0; k < 6; k++) drive(1, 1, 0, 0, 0);
        check("pre-reset d0", int'(val_o[0]), 6);
        check("pre-reset d1 sat", int'(sat_o[1]), 1);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("async d0 value", int'(val_o[0]), 0);
        check("async d1 sat", int'(sat_o[1]), 0);
        check("async d2 value", int'(val_o[2]), 0);
        check_model("async");
        @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            drive(1, 1, 0, 0, 0);
            check($sformatf("post-reset d2 edge%0d", k), int'(val_o[2]), 0);
        end
        drive(1, 1, 0, 0, 0);
        check("post-reset d2 edge4", int'(val_o[2]), 1);
        check("post-reset d0", int'(val_o[0]), 4);

        // ---- randomized stimulus against the model ----
        for (int k = 0; k < 400; k++) begin
            reset = ($urandom_range(0, 99) != 0);
            if (!reset) model_reset();
            drive(($urandom_range(0, 3) != 0), 1'($urandom),
                  ($urandom_range(0, 39) == 0), ($urandom_range(0, 24) == 0),
                  int'($urandom_range(0, 255)));
            check_model($sformatf("rand%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
